// File: rtl/sprite_pkg.sv
// Shared scan geometry, background colour and animation state encoding for the sprite renderer.
// Used by sprite_anim_renderer (optional SPRITE_FLIP_V_EN build) and sprite_anim_seq.
package sprite_pkg;

    localparam int SCAN_X_W = 10;
    localparam int SCAN_Y_W = 9;
    localparam logic [15:0] COLOR_BG = 16'hFFFF;

    typedef enum logic [0:0] {
        PLAY = 1'b0,
        DONE = 1'b1
    } anim_state_e;

    // Index width for a counter over n values, never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sprite_anim_renderer_if.sv
// Sprite ROM bus: registered address out, ROM word back one clock later.
interface sprite_anim_renderer_if #(
    parameter int ADDR_W = 16
);
    logic [ADDR_W-1:0] rom_addr;
    logic [15:0]       rom_data;

    modport master (output rom_addr, input rom_data);
    modport slave  (input rom_addr, output rom_data);
endinterface

// File: rtl/sprite_anim_seq.sv
// Animation frame sequencer: counts frame_tick pulses and steps frame_idx in loop or one-shot mode.
module sprite_anim_seq
    import sprite_pkg::*;
#(
    parameter int FRAMES      = 2,
    parameter int FRAME_TICKS = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      anim_en,
    input  logic                      one_shot,
    input  logic                      anim_restart,
    input  logic                      frame_tick,
    output logic [idx_w(FRAMES)-1:0]  frame_idx,
    output logic                      anim_done
);

    localparam int FI_W = idx_w(FRAMES);
    localparam int TC_W = idx_w(FRAME_TICKS);
    localparam logic [FI_W-1:0] FRAME_LAST = FI_W'(FRAMES - 1);
    localparam logic [TC_W-1:0] TICK_LAST  = TC_W'(FRAME_TICKS - 1);

    anim_state_e     state_r, state_s;
    logic [TC_W-1:0] tick_cnt_r, tick_cnt_s;
    logic [FI_W-1:0] frame_idx_r, frame_idx_s, frame_nxt_s;
    logic            anim_done_r, anim_done_s;

    // Sequencer state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= PLAY;
            tick_cnt_r  <= {TC_W{1'b0}};
            frame_idx_r <= {FI_W{1'b0}};
            anim_done_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            tick_cnt_r  <= tick_cnt_s;
            frame_idx_r <= frame_idx_s;
            anim_done_r <= anim_done_s;
        end
    end

    // Next-state logic; restart wins over any tick arriving in the same cycle.
    always_comb begin
        state_s     = state_r;
        tick_cnt_s  = tick_cnt_r;
        frame_idx_s = frame_idx_r;
        anim_done_s = 1'b0;
        if (frame_idx_r == FRAME_LAST) begin
            frame_nxt_s = {FI_W{1'b0}};
        end else begin
            frame_nxt_s = frame_idx_r + FI_W'(1);
        end

        if (anim_restart) begin
            state_s     = PLAY;
            tick_cnt_s  = {TC_W{1'b0}};
            frame_idx_s = {FI_W{1'b0}};
        end else begin
            case (state_r)
                PLAY: begin
                    if (frame_tick && anim_en) begin
                        if (tick_cnt_r == TICK_LAST) begin
                            tick_cnt_s  = {TC_W{1'b0}};
                            frame_idx_s = frame_nxt_s;
                            // one_shot is only consulted here, so a mid-play change applies at the next advance
                            if (one_shot && (frame_nxt_s == FRAME_LAST)) begin
                                state_s     = DONE;
                                anim_done_s = 1'b1;
                            end else begin
                                state_s = PLAY;
                            end
                        end else begin
                            tick_cnt_s = tick_cnt_r + TC_W'(1);
                        end
                    end else begin
                        tick_cnt_s = tick_cnt_r;
                    end
                end
                DONE: begin
                    state_s = DONE;
                end
                default: begin
                    state_s = PLAY;
                end
            endcase
        end
    end

    assign frame_idx = frame_idx_r;
    assign anim_done = anim_done_r;

endmodule

// File: rtl/sprite_anim_renderer.sv
// Sprite pixel source: box hit test, multi-frame ROM addressing and colour-key transparency, 2-clk latency.
// Optional build macro SPRITE_FLIP_V_EN adds the flip_v port for vertical mirroring.
module sprite_anim_renderer
    import sprite_pkg::*;
#(
    parameter int          WIDTH       = 177,
    parameter int          HEIGHT      = 117,
    parameter int          FRAMES      = 2,
    parameter int          FRAME_TICKS = 8,
    parameter logic [15:0] TRANSPARENT = 16'h0000,
    parameter int          ADDR_W      = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [SCAN_X_W-1:0]       x,
    input  logic [SCAN_Y_W-1:0]       y,
    input  logic [SCAN_X_W-1:0]       posx,
    input  logic [SCAN_Y_W-1:0]       posy,
    input  logic                      isplay,
    input  logic                      flip_h,
`ifdef SPRITE_FLIP_V_EN
    input  logic                      flip_v,
`endif
    input  logic                      anim_en,
    input  logic                      one_shot,
    input  logic                      anim_restart,
    input  logic                      frame_tick,
    sprite_anim_renderer_if.master    rom,
    output logic [15:0]               color,
    output logic                      is_display,
    output logic [idx_w(FRAMES)-1:0]  frame_idx,
    output logic                      anim_done
);

    localparam int FI_W = idx_w(FRAMES);
    localparam logic [SCAN_X_W:0]   WIDTH_X   = (SCAN_X_W + 1)'(WIDTH);
    localparam logic [SCAN_Y_W:0]   HEIGHT_Y  = (SCAN_Y_W + 1)'(HEIGHT);
    localparam logic [SCAN_X_W-1:0] WIDTH_M1  = SCAN_X_W'(WIDTH - 1);
    localparam logic [SCAN_Y_W-1:0] HEIGHT_M1 = SCAN_Y_W'(HEIGHT - 1);
    localparam logic [ADDR_W-1:0]   WIDTH_A   = ADDR_W'(WIDTH);
    localparam logic [ADDR_W-1:0]   FRAME_A   = ADDR_W'(WIDTH * HEIGHT);

    logic [SCAN_X_W:0]   x_end_s;
    logic [SCAN_Y_W:0]   y_end_s;
    logic                hit_s;
    logic [SCAN_X_W-1:0] dx_raw_s, dx_s;
    logic [SCAN_Y_W-1:0] dy_raw_s, dy_s;
    logic [ADDR_W-1:0]   addr_s;
    logic [ADDR_W-1:0]   rom_addr_r;
    logic                hit_r, hit_d1_r;
    logic [15:0]         color_r;
    logic                is_display_r;

    sprite_anim_seq #(
        .FRAMES      (FRAMES),
        .FRAME_TICKS (FRAME_TICKS)
    ) u_seq (
        .clk          (clk),
        .rst_n        (rst_n),
        .anim_en      (anim_en),
        .one_shot     (one_shot),
        .anim_restart (anim_restart),
        .frame_tick   (frame_tick),
        .frame_idx    (frame_idx),
        .anim_done    (anim_done)
    );

    // Stage 0: hit test and ROM address; far edges use one extra bit so boxes near 1023/511 do not wrap.
    always_comb begin
        x_end_s  = {1'b0, posx} + WIDTH_X;
        y_end_s  = {1'b0, posy} + HEIGHT_Y;
        hit_s    = isplay && (x >= posx) && ({1'b0, x} < x_end_s)
                          && (y >= posy) && ({1'b0, y} < y_end_s);
        dx_raw_s = x - posx;
        dy_raw_s = y - posy;
        if (flip_h) begin
            dx_s = WIDTH_M1 - dx_raw_s;
        end else begin
            dx_s = dx_raw_s;
        end
`ifdef SPRITE_FLIP_V_EN
        if (flip_v) begin
            dy_s = HEIGHT_M1 - dy_raw_s;
        end else begin
            dy_s = dy_raw_s;
        end
`else
        dy_s = dy_raw_s;
`endif
        addr_s = ADDR_W'(frame_idx) * FRAME_A + ADDR_W'(dy_s) * WIDTH_A + ADDR_W'(dx_s);
    end

    // Pixel pipeline: address/hit, hit delay aligned with ROM data, then key test and output colour.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rom_addr_r   <= {ADDR_W{1'b0}};
            hit_r        <= 1'b0;
            hit_d1_r     <= 1'b0;
            color_r      <= COLOR_BG;
            is_display_r <= 1'b0;
        end else begin
            rom_addr_r <= addr_s;
            hit_r      <= hit_s;
            hit_d1_r   <= hit_r;
            if (hit_d1_r && (rom.rom_data != TRANSPARENT)) begin
                color_r      <= rom.rom_data;
                is_display_r <= 1'b1;
            end else begin
                color_r      <= COLOR_BG;
                is_display_r <= 1'b0;
            end
        end
    end

    assign rom.rom_addr = rom_addr_r;
    assign color        = color_r;
    assign is_display   = is_display_r;

    logic unused_s;
    assign unused_s = &{1'b0, HEIGHT_M1};

endmodule

// File: tb/tb_sprite_anim_renderer.sv
// Scoreboard bench for sprite_anim_renderer: 8x4 sprite, 3 frames, 2 ticks/frame, ROM data = address.
module tb_sprite_anim_renderer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [9:0]  x = 10'd0, posx = 10'd100;
    logic [8:0]  y = 9'd0, posy = 9'd50;
    logic        isplay = 1'b1, flip_h = 1'b0, anim_en = 1'b1, one_shot = 1'b0;
    logic        anim_restart = 1'b0, frame_tick = 1'b0;
    logic [15:0] color;
    logic        is_display, anim_done;
    logic [1:0]  frame_idx;
    logic        stim_valid = 1'b0;
    logic [2:0]  v_d = 3'b000;
    int          tests = 0, fails = 0, done_cnt = 0;

    typedef struct {
        logic        chk;
        logic [15:0] addr;
        logic [15:0] col;
        logic        disp;
    } exp_t;
    exp_t aq[$];
    exp_t pq[$];

    sprite_anim_renderer_if #(.ADDR_W(16)) rom_if ();

    sprite_anim_renderer #(
        .WIDTH(8), .HEIGHT(4), .FRAMES(3), .FRAME_TICKS(2),
        .TRANSPARENT(16'h0000), .ADDR_W(16)
    ) dut (
        .clk(clk), .rst_n(rst_n), .x(x), .y(y), .posx(posx), .posy(posy),
        .isplay(isplay), .flip_h(flip_h),
`ifdef SPRITE_FLIP_V_EN
        .flip_v(1'b0),
`endif
        .anim_en(anim_en), .one_shot(one_shot), .anim_restart(anim_restart),
        .frame_tick(frame_tick), .rom(rom_if), .color(color),
        .is_display(is_display), .frame_idx(frame_idx), .anim_done(anim_done)
    );

    always #5 clk = ~clk;

    // Behavioural synchronous ROM whose word equals its address.
    always @(posedge clk) rom_if.rom_data <= rom_if.rom_addr;

    always @(posedge clk) v_d <= {v_d[1:0], stim_valid};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: address one clk after issue, pixel two clks after the sampling edge.
    always @(negedge clk) begin
        exp_t e;
        if (anim_done) done_cnt++;
        if (v_d[0]) begin
            if (aq.size() == 0) begin
                tests++; fails++;
                $display("FAIL addr_queue: got empty expected entry");
            end else begin
                e = aq.pop_front();
                if (e.chk) check("rom_addr", 32'(rom_if.rom_addr), 32'(e.addr));
            end
        end
        if (v_d[2]) begin
            if (pq.size() == 0) begin
                tests++; fails++;
                $display("FAIL pix_queue: got empty expected entry");
            end else begin
                e = pq.pop_front();
                check("color", 32'(color), 32'(e.col));
                check("is_display", 32'(is_display), 32'(e.disp));
            end
        end
    end

    task automatic pix(input logic [9:0] px, input logic [8:0] py, input logic fh,
                       input logic ca, input logic [15:0] ea, input logic [15:0] ec, input logic ed);
        @(posedge clk); #2;
        x = px; y = py; flip_h = fh; stim_valid = 1'b1;
        aq.push_back('{ca, ea, ec, ed});
        pq.push_back('{ca, ea, ec, ed});
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #2;
            stim_valid = 1'b0;
        end
    endtask

    task automatic tick(input logic rs);
        @(posedge clk); #2;
        stim_valid = 1'b0; frame_tick = 1'b1; anim_restart = rs;
        @(posedge clk); #2;
        frame_tick = 1'b0; anim_restart = 1'b0;
    endtask

    initial begin
        int loop_seq[6];
        int d0;
        loop_seq = '{1, 1, 2, 2, 0, 0};
        loop_seq = '{0, 1, 1, 2, 2, 0};

        repeat (3) @(posedge clk);
        #1;
        check("rst_color", 32'(color), 32'hFFFF);
        check("rst_disp", 32'(is_display), 32'd0);
        check("rst_addr", 32'(rom_if.rom_addr), 32'd0);
        check("rst_frame", 32'(frame_idx), 32'd0);
        check("rst_done", 32'(anim_done), 32'd0);
        #1 rst_n = 1'b1;

        // Frame 0 pixel vectors, issued back to back.
        pix(10'd103, 9'd51, 1'b0, 1'b1, 16'd11, 16'h000B, 1'b1);
        pix(10'd103, 9'd51, 1'b1, 1'b1, 16'd12, 16'h000C, 1'b1);
        pix(10'd108, 9'd51, 1'b0, 1'b0, 16'd0,  16'hFFFF, 1'b0);
        pix(10'd103, 9'd54, 1'b0, 1'b0, 16'd0,  16'hFFFF, 1'b0);
        pix(10'd99,  9'd51, 1'b0, 1'b0, 16'd0,  16'hFFFF, 1'b0);
        pix(10'd107, 9'd53, 1'b0, 1'b1, 16'd31, 16'h001F, 1'b1);
        pix(10'd100, 9'd50, 1'b0, 1'b1, 16'd0,  16'hFFFF, 1'b0);
        pix(10'd100, 9'd53, 1'b1, 1'b1, 16'd31, 16'h001F, 1'b1);
        idle(4);
        isplay = 1'b0;
        pix(10'd103, 9'd51, 1'b0, 1'b1, 16'd11, 16'hFFFF, 1'b0);
        idle(1);
        isplay = 1'b1;
        idle(4);

        // Loop mode: frame sequence after each tick, with a frame-2 scan in between.
        for (int i = 0; i < 6; i++) begin
            tick(1'b0);
            check($sformatf("loop_frame%0d", i), 32'(frame_idx), 32'(loop_seq[i]));
            if (i == 3) begin
                pix(10'd100, 9'd50, 1'b0, 1'b1, 16'd64, 16'h0040, 1'b1);
                idle(4);
            end
        end

        // Ticks are ignored while anim_en is low.
        anim_en = 1'b0;
        tick(1'b0);
        tick(1'b0);
        check("hold_frame", 32'(frame_idx), 32'd0);
        anim_en = 1'b1;

        // One-shot: stop on frame 2 with a single done pulse.
        one_shot = 1'b1;
        d0 = done_cnt;
        for (int i = 0; i < 4; i++) tick(1'b0);
        check("oneshot_frame", 32'(frame_idx), 32'd2);
        check("oneshot_done_hi", 32'(anim_done), 32'd1);
        idle(1);
        check("oneshot_done_lo", 32'(anim_done), 32'd0);
        tick(1'b0);
        tick(1'b0);
        check("done_hold_frame", 32'(frame_idx), 32'd2);
        check("done_pulses", 32'(done_cnt - d0), 32'd1);

        // Restart with a simultaneous tick clears tick_cnt and frame, no done pulse.
        d0 = done_cnt;
        tick(1'b1);
        check("restart_frame", 32'(frame_idx), 32'd0);
        check("restart_done", 32'(anim_done), 32'd0);
        tick(1'b0);
        check("restart_tick1", 32'(frame_idx), 32'd0);
        tick(1'b0);
        check("restart_tick2", 32'(frame_idx), 32'd1);
        check("restart_pulses", 32'(done_cnt - d0), 32'd0);

        // Mid-scan reset while frame 1 is showing.
        @(posedge clk); #2;
        x = 10'd103; y = 9'd51; flip_h = 1'b0;
        idle(3);
        check("pre_rst_color", 32'(color), 32'h002B);
        check("pre_rst_disp", 32'(is_display), 32'd1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("mid_rst_color", 32'(color), 32'hFFFF);
        check("mid_rst_disp", 32'(is_display), 32'd0);
        check("mid_rst_frame", 32'(frame_idx), 32'd0);
        check("mid_rst_addr", 32'(rom_if.rom_addr), 32'd0);
        #1 rst_n = 1'b1;
        pix(10'd103, 9'd51, 1'b0, 1'b1, 16'd11, 16'h000B, 1'b1);
        idle(5);

        check("queues_empty", 32'(aq.size() + pq.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
